// File: rtl/serial_tx_pkg.sv
// ============================================================================
// Module   : serial_tx_pkg
// Brief    : Shared types, default sizes and length helper for serial_pattern_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    localparam int c_width_def = 8;
    localparam int c_len_w_def = 4;

    // A requested length of 0 or beyond the payload width means a full-width frame.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned width = c_width_def);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_shift_reg.sv
// ============================================================================
// Module   : tx_shift_reg
// Brief    : Loadable left shifter presenting the next frame bit and running parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_shift_reg
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = c_width_def,
    parameter int LEN_W = c_len_w_def
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_bit,
    output logic             o_par
);

    logic [WIDTH-1:0] r_sh;
    logic             r_par;
    logic [LEN_W-1:0] w_amt;

    // Left-align the selected field so its top bit sits at the MSB.
    assign w_amt = LEN_W'(WIDTH) - i_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_par <= 1'b0;
        end else if (i_load) begin
            r_sh  <= i_data << w_amt;
            r_par <= 1'b0;
        end else if (i_shift) begin
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_par <= r_par ^ r_sh[WIDTH-1];
        end
    end

    assign o_bit = r_sh[WIDTH-1];
    assign o_par = r_par;

endmodule

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// Module   : serial_pattern_tx
// Brief    : Serial bit-pattern transmitter, MSB of field first, back-to-back capable.
//            Define TX_PARITY_EN to append an even-parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = c_width_def,
    parameter int LEN_W = c_len_w_def
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

`ifdef TX_PARITY_EN
    localparam tx_state_t c_after_last = PARITY;
`else
    localparam tx_state_t c_after_last = IDLE;
`endif

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] w_len;
    logic             w_last_bit;
    logic             w_accept;
    logic             w_shift;
    logic             w_bit;
    logic             w_par;

    assign w_len      = LEN_W'(eff_len(32'(load_len), WIDTH));
    assign w_last_bit = (r_state == SHIFT) && (r_cnt == '0);

`ifdef TX_PARITY_EN
    assign load_ready = rst_n && ((r_state == IDLE) || (r_state == PARITY));
    assign done       = (r_state == PARITY);
`else
    assign load_ready = rst_n && ((r_state == IDLE) || w_last_bit);
    assign done       = w_last_bit;
`endif

    assign w_accept = load_valid & load_ready;
    // A new load on the final cycle replaces the shift so the next frame follows with no gap.
    assign w_shift  = (r_state == SHIFT) & ~w_accept;

    tx_shift_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (load_data),
        .i_len   (w_len),
        .o_bit   (w_bit),
        .o_par   (w_par)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = w_len - LEN_W'(1);
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - LEN_W'(1);
                    end else begin
                        w_state_nxt = c_after_last;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == SHIFT) || (r_state == PARITY);
    assign out       = (r_state == SHIFT)  ? w_bit :
                       (r_state == PARITY) ? w_par : 1'b0;

endmodule

`default_nettype wire
